// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the Gray counter family.
// Conversion functions work on up to MAX_W bits; bits at or above 'width' are ignored.
package gray_pkg;

  localparam int MAX_W       = 32;
  localparam int ERR_CNT_MAX = 255;

  typedef enum logic {INIT, TRACK} state_t;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    logic [MAX_W-1:0] m;
    if (width >= MAX_W) m = '1;
    else                m = (MAX_W'(1) << width) - MAX_W'(1);
    return m;
  endfunction

  // Binary is the running XOR of the Gray word shifted down by every amount.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int width);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(width);
    b  = gm;
    for (int i = 1; i < MAX_W; i++) b = b ^ (gm >> i);
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int width);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational N-bit Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above it.
module gray_to_bin #(
  parameter int N = 8
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign bin[gi] = ^gray[N-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_count_decoder.sv
// Synchronises a Gray-coded count, converts it to binary and tracks an
// M-bit position by classifying every sample-to-sample step.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic [N-1:0] gray_in,
  input  logic         clear_in,
  output logic [N-1:0] bin_out,
  output logic [M-1:0] pos_out,
  output logic         up_out,
  output logic         down_out,
  output logic         err_out,
  output logic [7:0]   err_cnt_out,
  output logic         valid_out
);

  localparam int            CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  bin_comb;
  logic [N-1:0]                  bin_q;
  logic [N-1:0]                  prev_q;
  logic [N-1:0]                  delta;
  state_t                        state;
  logic [CW-1:0]                 init_cnt;
  logic [M-1:0]                  pos_q;
  logic                          up_q;
  logic                          down_q;
  logic                          err_q;
  logic [7:0]                    err_cnt_q;
  logic                          valid_q;

  gray_to_bin #(.N(N)) u_gray_to_bin (
    .gray (sync_q[SYNC_STAGES-1]),
    .bin  (bin_comb)
  );

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      sync_q <= '0;
      bin_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
      bin_q  <= bin_comb;
    end
  end

  // Modular difference: +1 and all-ones cover the wrap between 2^N-1 and 0.
  assign delta = bin_q - prev_q;

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      state     <= INIT;
      init_cnt  <= '0;
      prev_q    <= '0;
      pos_q     <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      case (state)
        INIT: begin
          // Wait until bin_q carries a value that really came through the synchroniser.
          if (init_cnt == INIT_LAST) begin
            pos_q   <= M'(bin_q);
            prev_q  <= bin_q;
            valid_q <= 1'b1;
            state   <= TRACK;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        default: begin
          prev_q <= bin_q;
          if (clear_in) begin
            pos_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
          end else if (delta == N'(1)) begin
            pos_q <= pos_q + M'(1);
            up_q  <= 1'b1;
          end else if (delta == '1) begin
            pos_q  <= pos_q - M'(1);
            down_q <= 1'b1;
          end else if (delta != '0) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'(ERR_CNT_MAX)) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bin_out     = bin_q;
  assign pos_out     = pos_q;
  assign up_out      = up_q;
  assign down_out    = down_q;
  assign err_out     = err_q;
  assign err_cnt_out = err_cnt_q;
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Randomised and directed stimulus for gray_count_decoder against a
// history-based reference model of the sample/convert/classify behaviour.
module tb_gray_count_decoder;

  localparam int N = 8;
  localparam int M = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_ah_in;
  logic [N-1:0] gray_in;
  logic         clear_in;
  logic [N-1:0] bin_out;
  logic [M-1:0] pos_out;
  logic         up_out;
  logic         down_out;
  logic         err_out;
  logic [7:0]   err_cnt_out;
  logic         valid_out;

  gray_count_decoder #(.N(N), .M(M), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .gray_in     (gray_in),
    .clear_in    (clear_in),
    .bin_out     (bin_out),
    .pos_out     (pos_out),
    .up_out      (up_out),
    .down_out    (down_out),
    .err_out     (err_out),
    .err_cnt_out (err_cnt_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: gray value seen at each edge since reset release, and expected outputs.
  int dec_tbl [256];
  int hist [$];
  int k;
  int m_bin, m_pos, m_up, m_down, m_err, m_cnt, m_valid;
  int dut_ups, dut_downs;
  int cur;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int enc(input int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  task automatic model_reset();
    k = 0;
    hist.delete();
    m_bin = 0; m_pos = 0; m_up = 0; m_down = 0;
    m_err = 0; m_cnt = 0; m_valid = 0;
  endtask

  task automatic model_edge(input int g, input logic clr);
    int now_v, before_v, d;
    k++;
    hist.push_back(g);
    m_up   = 0;
    m_down = 0;
    m_bin  = (k >= S + 1) ? dec_tbl[hist[k-S-1]] : 0;
    if (k == S + 2) begin
      m_valid = 1;
      m_pos   = dec_tbl[hist[0]];
    end else if (k > S + 2) begin
      now_v    = dec_tbl[hist[k-S-2]];
      before_v = dec_tbl[hist[k-S-3]];
      d = (now_v - before_v) & 255;
      if (clr) begin
        m_pos = 0; m_err = 0; m_cnt = 0;
      end else if (d == 1) begin
        m_pos = (m_pos + 1) & 16'hFFFF;
        m_up  = 1;
      end else if (d == 255) begin
        m_pos  = (m_pos - 1) & 16'hFFFF;
        m_down = 1;
      end else if (d != 0) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    check_val("bin_out",     bin_out,     m_bin);
    check_val("pos_out",     pos_out,     m_pos);
    check_val("up_out",      up_out,      m_up);
    check_val("down_out",    down_out,    m_down);
    check_val("err_out",     err_out,     m_err);
    check_val("err_cnt_out", err_cnt_out, m_cnt);
    check_val("valid_out",   valid_out,   m_valid);
  endtask

  task automatic tick();
    int  g;
    logic c, r;
    @(posedge clk);
    g = int'(gray_in);
    c = clear_in;
    r = reset_ah_in;
    #1;
    if (r) model_reset();
    else   model_edge(g, c);
    if (up_out)   dut_ups++;
    if (down_out) dut_downs++;
    compare_all();
  endtask

  task automatic set_bin(input int b);
    cur     = b & 255;
    gray_in = N'(enc(cur));
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Reset with the given binary value on gray_in, ending just after valid_out rises.
  task automatic do_reset(input int init_bin);
    reset_ah_in = 1'b1;
    clear_in    = 1'b0;
    set_bin(init_bin);
    drain(2);
    reset_ah_in = 1'b0;
    drain(S + 2);
  endtask

  initial begin
    for (int v = 0; v < 256; v++) dec_tbl[enc(v)] = v;
    model_reset();
    dut_ups   = 0;
    dut_downs = 0;

    // Power-up with gray held at zero.
    reset_ah_in = 1'b1;
    clear_in    = 1'b0;
    set_bin(0);
    drain(2);
    reset_ah_in = 1'b0;
    drain(3);
    check_val("valid_before_e4", valid_out, 0);
    tick();
    check_val("valid_at_e4", valid_out, 1);
    check_val("pos_after_init", pos_out, 0);
    $display("phase reset: pos=%0d bin=%0d valid=%0d", pos_out, bin_out, valid_out);

    // Full lap of an 8-bit Gray counter.
    dut_ups = 0;
    for (int i = 1; i <= 256; i++) begin
      set_bin(i);
      tick();
    end
    drain(4);
    check_val("lap_pos", pos_out, 16'h0100);
    check_val("lap_ups", dut_ups, 256);
    check_val("lap_err", err_out, 0);
    $display("phase count-up: pos=%0h ups=%0d err=%0d", pos_out, dut_ups, err_out);

    // Down steps from 5, then through 0 to 255.
    do_reset(5);
    check_val("down_start_pos", pos_out, 5);
    dut_downs = 0;
    set_bin(4); tick();
    set_bin(3); tick();
    drain(4);
    check_val("down_pos3", pos_out, 3);
    check_val("down_pulses", dut_downs, 2);
    for (int b = 2; b >= -1; b--) begin
      set_bin(b);
      tick();
    end
    drain(4);
    check_val("down_wrap_pos", pos_out, 16'hFFFF);
    $display("phase count-down: pos=%0h downs=%0d", pos_out, dut_downs);

    // Illegal jump, legal step, then saturation of the error counter.
    do_reset(0);
    gray_in = 8'h03;
    cur = 2;
    drain(4);
    check_val("jump_err", err_out, 1);
    check_val("jump_cnt", err_cnt_out, 1);
    check_val("jump_pos", pos_out, 0);
    set_bin(3);
    drain(4);
    check_val("after_jump_pos", pos_out, 1);
    for (int i = 0; i < 300; i++) begin
      set_bin((i % 2 == 0) ? 10 : 3);
      tick();
    end
    drain(4);
    check_val("sat_cnt", err_cnt_out, 255);
    check_val("sat_err", err_out, 1);
    $display("phase errors: err=%0d err_cnt=%0d pos=%0d", err_out, err_cnt_out, pos_out);

    // Clear coinciding with an up step at position 37.
    do_reset(37);
    set_bin(50); tick();
    set_bin(37); tick();
    drain(4);
    check_val("pre_clear_pos", pos_out, 37);
    check_val("pre_clear_cnt", err_cnt_out, 2);
    set_bin(38);
    drain(3);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check_val("clear_pos", pos_out, 0);
    check_val("clear_err", err_out, 0);
    check_val("clear_cnt", err_cnt_out, 0);
    check_val("clear_no_up", up_out, 0);
    set_bin(39);
    drain(4);
    check_val("post_clear_pos", pos_out, 1);
    $display("phase clear: pos=%0d err=%0d err_cnt=%0d", pos_out, err_out, err_cnt_out);

    // Random walk with occasional jumps and clears.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 7)       set_bin(cur + 1);
      else if (r < 13) set_bin(cur - 1);
      else if (r < 17) set_bin(cur);
      else             set_bin(cur + int'($urandom_range(2, 254)));
      clear_in = ($urandom_range(0, 24) == 0);
      tick();
    end
    clear_in = 1'b0;
    drain(4);
    $display("phase random: pos=%0d err_cnt=%0d", pos_out, err_cnt_out);

    // Asynchronous reset in mid-stream at position 37.
    do_reset(37);
    set_bin(38); tick();
    set_bin(37); tick();
    drain(4);
    check_val("mid_pos37", pos_out, 37);
    #2;
    reset_ah_in = 1'b1;
    #1;
    check_val("async_bin",   bin_out,     0);
    check_val("async_pos",   pos_out,     0);
    check_val("async_up",    up_out,      0);
    check_val("async_down",  down_out,    0);
    check_val("async_err",   err_out,     0);
    check_val("async_cnt",   err_cnt_out, 0);
    check_val("async_valid", valid_out,   0);
    model_reset();
    set_bin(200);
    drain(2);
    reset_ah_in = 1'b0;
    drain(3);
    check_val("rst_valid_pre", valid_out, 0);
    tick();
    check_val("rst_valid_e4", valid_out, 1);
    check_val("rst_reload_pos", pos_out, 200);
    $display("phase mid-reset: pos=%0d valid=%0d", pos_out, valid_out);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
